// File: rtl/aes_block_packer.sv
// Packs 32-bit streamer words into 128-bit AES blocks. One assembly register and
// one output register decouple word-rate input from block-rate core handshakes.
module aes_block_packer #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic [CNT_W-1:0]    nblocks_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [WORD_W-1:0]   in_data_i,
  input  logic [3:0]          in_strb_i,
  output logic                blk_valid_o,
  input  logic                blk_ready_i,
  output logic [4*WORD_W-1:0] blk_data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_strb_o
);

  localparam int BLK_W = 4 * WORD_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             r_state;
  logic [1:0]         r_word_cnt;
  logic [BLK_W-1:0]   r_asm;
  logic               r_asm_full;
  logic [CNT_W-1:0]   r_blk_in;
  logic [CNT_W-1:0]   r_blk_out;
  logic [CNT_W-1:0]   r_blk_total;
  logic               r_blk_valid;
  logic [BLK_W-1:0]   r_blk_data;
  logic               r_done;
  logic               r_err_strb;

  logic               w_run;
  logic               w_in_ready;
  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_out_free;
  logic               w_last_word;
  logic               w_strb_bad;
  logic [BLK_W-1:0]   w_blk_new;
  logic [CNT_W-1:0]   w_blk_out_nxt;

  assign w_run         = (r_state == S_RUN);
  // Ready is a pure function of registers so upstream never sees a comb path.
  assign w_in_ready    = w_run & ~r_asm_full & (r_blk_in < r_blk_total);
  assign w_in_fire     = in_valid_i & w_in_ready;
  assign w_out_fire    = r_blk_valid & blk_ready_i;
  assign w_out_free    = ~r_blk_valid | blk_ready_i;
  assign w_last_word   = w_in_fire & (r_word_cnt == 2'd3);
  assign w_strb_bad    = (in_strb_i != 4'hF);
  assign w_blk_new     = {in_data_i, r_asm[3*WORD_W-1:0]};
  assign w_blk_out_nxt = r_blk_out + CNT_W'(w_out_fire);

  assign in_ready_o  = w_in_ready;
  assign blk_valid_o = r_blk_valid;
  assign blk_data_o  = r_blk_data;
  assign busy_o      = w_run;
  assign done_o      = r_done;
  assign err_strb_o  = r_err_strb;

  // Assembly buffer: pure datapath, partial contents are qualified by r_word_cnt.
  always_ff @(posedge clk_i) begin
    if (w_in_fire) begin
      r_asm[r_word_cnt*WORD_W +: WORD_W] <= in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_word_cnt  <= 2'd0;
      r_asm_full  <= 1'b0;
      r_blk_in    <= '0;
      r_blk_out   <= '0;
      r_blk_total <= '0;
      r_blk_valid <= 1'b0;
      r_blk_data  <= '0;
      r_done      <= 1'b0;
      r_err_strb  <= 1'b0;
    end else if (clear_i) begin
      r_state     <= S_IDLE;
      r_word_cnt  <= 2'd0;
      r_asm_full  <= 1'b0;
      r_blk_in    <= '0;
      r_blk_out   <= '0;
      r_blk_total <= '0;
      r_blk_valid <= 1'b0;
      r_blk_data  <= '0;
      r_done      <= 1'b0;
      r_err_strb  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_blk_total <= nblocks_i;
            r_word_cnt  <= 2'd0;
            r_blk_in    <= '0;
            r_blk_out   <= '0;
            r_asm_full  <= 1'b0;
            r_err_strb  <= 1'b0;
            if (nblocks_i == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_in_fire) begin
            r_word_cnt <= r_word_cnt + 2'd1;
            if (w_strb_bad) r_err_strb <= 1'b1;
          end
          if (w_last_word) r_blk_in <= r_blk_in + CNT_W'(1);
          r_blk_out <= w_blk_out_nxt;
          // A parked block always wins the output slot; ready is low while parked.
          if (r_asm_full && w_out_free) begin
            r_blk_data  <= r_asm;
            r_blk_valid <= 1'b1;
            r_asm_full  <= 1'b0;
          end else if (w_last_word && w_out_free) begin
            r_blk_data  <= w_blk_new;
            r_blk_valid <= 1'b1;
          end else begin
            if (w_last_word) r_asm_full <= 1'b1;
            if (w_out_fire) r_blk_valid <= 1'b0;
          end
          if (w_blk_out_nxt == r_blk_total) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_packer.sv
// Directed bench for aes_block_packer: a queue-based block model is compared against
// the DUT on every falling edge, plus hand-computed literal expectations per scenario.
module tb_aes_block_packer;

  logic         clk_i;
  logic         rst_ni;
  logic         clear_i;
  logic         start_i;
  logic [15:0]  nblocks_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [31:0]  in_data_i;
  logic [3:0]   in_strb_i;
  logic         blk_valid_o;
  logic         blk_ready_i;
  logic [127:0] blk_data_o;
  logic         busy_o;
  logic         done_o;
  logic         err_strb_o;

  aes_block_packer #(.WORD_W(32), .CNT_W(16)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .nblocks_i   (nblocks_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_strb_i   (in_strb_i),
    .blk_valid_o (blk_valid_o),
    .blk_ready_i (blk_ready_i),
    .blk_data_o  (blk_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_strb_o  (err_strb_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_done = 0;
  int n_blk  = 0;
  bit chk_en = 0;
  logic [127:0] obs_last = '0;

  // Model: job phase (0 idle, 1 run, 2 done), completed blocks waiting for the core
  // in mq (head is the one on the output), last drained block kept for data hold.
  int           ms = 0;
  int           m_total = 0;
  int           m_wblk = 0;
  int           m_win = 0;
  int           m_bout = 0;
  int           m_wacc = 0;
  bit           m_err = 0;
  logic [127:0] m_part = '0;
  logic [127:0] m_last = '0;
  logic [127:0] mq[$];
  bit           fin, fout;

  function automatic bit e_ready();
    return (ms == 1) && (mq.size() < 2) && (m_win < 4 * m_total);
  endfunction

  function automatic logic [127:0] e_data();
    return (mq.size() > 0) ? mq[0] : m_last;
  endfunction

  task automatic model_clear();
    ms = 0; m_total = 0; m_wblk = 0; m_win = 0; m_bout = 0; m_err = 0;
    mq.delete(); m_last = '0;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  initial forever begin
    @(posedge clk_i or negedge rst_ni);
    if (!rst_ni || clear_i) begin
      model_clear();
    end else begin
      fin  = e_ready() && in_valid_i;
      fout = (mq.size() > 0) && blk_ready_i;
      case (ms)
        0: if (start_i) begin
          m_total = int'(nblocks_i); m_wblk = 0; m_win = 0; m_bout = 0; m_err = 0;
          ms = (m_total == 0) ? 2 : 1;
        end
        1: begin
          if (fout) begin
            m_last = mq.pop_front();
            m_bout++;
          end
          if (fin) begin
            m_part[m_wblk*32 +: 32] = in_data_i;
            m_wblk++; m_win++; m_wacc++;
            if (in_strb_i != 4'hF) m_err = 1;
            if (m_wblk == 4) begin
              mq.push_back(m_part);
              m_wblk = 0;
            end
          end
          if (m_bout == m_total) ms = 2;
        end
        default: ms = 0;
      endcase
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (chk_en) begin
      chk("in_ready", {127'b0, in_ready_o}, {127'b0, e_ready()});
      chk("blk_valid", {127'b0, blk_valid_o}, {127'b0, mq.size() > 0});
      chk("blk_data", blk_data_o, e_data());
      chk("busy", {127'b0, busy_o}, {127'b0, ms == 1});
      chk("done", {127'b0, done_o}, {127'b0, ms == 2});
      chk("err_strb", {127'b0, err_strb_o}, {127'b0, m_err});
      if (done_o) n_done++;
      if (blk_valid_o && blk_ready_i) begin
        n_blk++;
        obs_last = blk_data_o;
      end
    end
  end

  task automatic start_job(input int n);
    nblocks_i = 16'(n);
    start_i = 1;
    @(posedge clk_i); #1;
    start_i = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] s);
    int target;
    target = m_wacc + 1;
    in_valid_i = 1; in_data_i = d; in_strb_i = s;
    for (int k = 0; k < 200 && m_wacc != target; k++) begin
      @(posedge clk_i); #1;
    end
    in_valid_i = 0;
    if (m_wacc != target) begin
      total++; bad++;
      $display("FAIL send_timeout: word %0h not accepted, got %0d words expected %0d", d, m_wacc, target);
    end
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 500 && ms != 0; k++) begin
      @(posedge clk_i); #1;
    end
    if (ms != 0) begin
      total++; bad++;
      $display("FAIL idle_timeout: job still active, got phase %0d expected 0", ms);
    end
  endtask

  int d0, b0, c0;

  initial begin
    rst_ni = 0; clear_i = 0; start_i = 0; nblocks_i = '0;
    in_valid_i = 0; in_data_i = '0; in_strb_i = 4'hF; blk_ready_i = 1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_in_ready", {127'b0, in_ready_o}, 128'h0);
    chk("rst_blk_valid", {127'b0, blk_valid_o}, 128'h0);
    chk("rst_blk_data", blk_data_o, 128'h0);
    chk("rst_busy", {127'b0, busy_o}, 128'h0);
    chk("rst_done", {127'b0, done_o}, 128'h0);
    chk("rst_err", {127'b0, err_strb_o}, 128'h0);
    rst_ni = 1;
    chk_en = 1;
    @(posedge clk_i); #1;

    // Single block
    d0 = n_done;
    start_job(1);
    chk("t1_busy", {127'b0, busy_o}, 128'h1);
    chk("t1_ready", {127'b0, in_ready_o}, 128'h1);
    send(32'h00112233, 4'hF);
    send(32'h44556677, 4'hF);
    send(32'h8899AABB, 4'hF);
    send(32'hCCDDEEFF, 4'hF);
    chk("t1_valid", {127'b0, blk_valid_o}, 128'h1);
    chk("t1_data", blk_data_o, 128'hCCDDEEFF_8899AABB_44556677_00112233);
    @(posedge clk_i); #1;
    chk("t1_done", {127'b0, done_o}, 128'h1);
    chk("t1_busy_off", {127'b0, busy_o}, 128'h0);
    @(posedge clk_i); #1;
    chk("t1_done_off", {127'b0, done_o}, 128'h0);
    chk("t1_data_hold", blk_data_o, 128'hCCDDEEFF_8899AABB_44556677_00112233);

    // Streaming 4 blocks back-to-back
    d0 = n_done; b0 = n_blk;
    start_job(4);
    c0 = cyc;
    for (int i = 0; i < 16; i++) send(32'hA0000000 + 32'(i) * 32'h00010101, 4'hF);
    chk("t2_cycles", 128'(cyc - c0), 128'd16);
    wait_idle();
    chk("t2_blocks", 128'(n_blk - b0), 128'd4);
    chk("t2_done_cnt", 128'(n_done - d0), 128'd1);

    // Backpressure
    blk_ready_i = 0;
    b0 = n_blk;
    start_job(3);
    for (int i = 1; i <= 8; i++) send(32'h30000000 + 32'(i), 4'hF);
    chk("t3_ready_low", {127'b0, in_ready_o}, 128'h0);
    chk("t3_valid", {127'b0, blk_valid_o}, 128'h1);
    chk("t3_head", blk_data_o, 128'h30000004_30000003_30000002_30000001);
    repeat (3) begin @(posedge clk_i); #1; end
    blk_ready_i = 1;
    for (int i = 9; i <= 12; i++) send(32'h30000000 + 32'(i), 4'hF);
    wait_idle();
    chk("t3_blocks", 128'(n_blk - b0), 128'd3);
    chk("t3_last", obs_last, 128'h3000000C_3000000B_3000000A_30000009);

    // Strobe error
    start_job(1);
    send(32'h11111111, 4'hF);
    send(32'h22222222, 4'h7);
    chk("t4_err", {127'b0, err_strb_o}, 128'h1);
    send(32'h33333333, 4'hF);
    send(32'h44444444, 4'hF);
    chk("t4_data", blk_data_o, 128'h44444444_33333333_22222222_11111111);
    wait_idle();
    chk("t4_err_sticky", {127'b0, err_strb_o}, 128'h1);

    // Clear mid-block
    start_job(2);
    chk("t5_err_cleared", {127'b0, err_strb_o}, 128'h0);
    send(32'hDEADBEEF, 4'hF);
    send(32'hBADC0FFE, 4'hF);
    clear_i = 1;
    @(posedge clk_i); #1;
    clear_i = 0;
    chk("t5_busy", {127'b0, busy_o}, 128'h0);
    chk("t5_ready", {127'b0, in_ready_o}, 128'h0);
    chk("t5_valid", {127'b0, blk_valid_o}, 128'h0);
    chk("t5_data", blk_data_o, 128'h0);
    chk("t5_done", {127'b0, done_o}, 128'h0);
    start_job(1);
    send(32'h01020304, 4'hF);
    send(32'h05060708, 4'hF);
    send(32'h090A0B0C, 4'hF);
    send(32'h0D0E0F10, 4'hF);
    chk("t5_fresh", blk_data_o, 128'h0D0E0F10_090A0B0C_05060708_01020304);
    wait_idle();

    // Zero-block job, then start ignored while running
    start_job(0);
    chk("t6_done", {127'b0, done_o}, 128'h1);
    chk("t6_ready", {127'b0, in_ready_o}, 128'h0);
    @(posedge clk_i); #1;
    chk("t6_done_off", {127'b0, done_o}, 128'h0);
    d0 = n_done; b0 = n_blk;
    start_job(2);
    start_i = 1; nblocks_i = 16'd1;
    send(32'h60000000, 4'hF);
    start_i = 0;
    for (int i = 1; i < 8; i++) send(32'h60000000 + 32'(i), 4'hF);
    wait_idle();
    chk("t6_blocks", 128'(n_blk - b0), 128'd2);
    chk("t6_done_cnt", 128'(n_done - d0), 128'd1);

    // Asynchronous reset mid-job
    blk_ready_i = 0;
    start_job(2);
    for (int i = 0; i < 5; i++) send(32'h70000000 + 32'(i), 4'hF);
    #2 rst_ni = 0;
    #1;
    chk("t7_valid", {127'b0, blk_valid_o}, 128'h0);
    chk("t7_busy", {127'b0, busy_o}, 128'h0);
    chk("t7_data", blk_data_o, 128'h0);
    @(posedge clk_i); #1;
    rst_ni = 1;
    blk_ready_i = 1;
    repeat (2) begin @(posedge clk_i); #1; end
    chk("t7_idle", {127'b0, busy_o}, 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_block_packer.md
# aes_block_packer

Upstream stage of the AES HWPE engine: gathers 32-bit words from the streamer's input stream into 128-bit AES state blocks and hands each complete block to the cipher core over a valid/ready block interface. It decouples word-level streamer traffic from block-level core consumption with one assembly register plus one output register. This sustains one word per cycle while the core accepts blocks. Per-job block count, completion pulse and strobe-error flag are exposed to the controller.

## Interface
- Parameters:
- WORD_W, 32: input word width; fixed at 32, block width = 4*WORD_W.
- CNT_W, 16: width of block counters.
- Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- clear_i  in  1  synchronous soft clear; highest priority.
- start_i  in  1  job start pulse; sampled only in IDLE.
- nblocks_i  in  CNT_W  blocks in the job; sampled with start_i.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  input word ready.
- in_data_i  in  32  input word.
- in_strb_i  in  4  byte strobes; 4'hF required.
- blk_valid_o  out  1  output block valid.
- blk_ready_i  in  1  output block ready.
- blk_data_o  out  128  output block; word k of the block at bits [32k+31:32k].
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse at job end.
- err_strb_o  out  1  sticky: an accepted word had strobe != 4'hF.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready_o=0. start_i=1 latches nblocks_i into blk_total, clears word_cnt (2 bit), blk_in, blk_out and err_strb_o, then goes to RUN. If nblocks_i=0, go to DONE instead.
- RUN, word accept: transfer when in_valid_i & in_ready_o.
  - Word is written to asm[word_cnt*32 +: 32] and word_cnt increments, wrapping 3->0.
  - Any in_strb_i != 4'hF sets err_strb_o. The data is still taken.
- in_ready_o = RUN & !asm_full & (blk_in < blk_total). It depends on registers only.
- 4th word accepted (word_cnt=3):
  - If the output register is empty, or blk_valid_o & blk_ready_i in the same cycle, the completed block (asm plus current word) loads directly into blk_data_o and blk_valid_o=1.
  - Otherwise the block stays in asm and asm_full=1.
  - blk_in increments in either case.
- asm_full=1: asm moves to the output register in the cycle the output register is empty or draining; asm_full then clears.
- Block accept (blk_valid_o & blk_ready_i):
  - blk_out increments.
  - blk_valid_o drops unless a new block loads in the same cycle.
  - blk_data_o holds its value after drain. It is not cleared.
- RUN -> DONE when blk_out reaches blk_total, including the cycle of the final block accept.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- start_i in RUN/DONE: ignored.
- clear_i: next state IDLE. All counters, asm_full, blk_valid_o, done_o, busy_o and err_strb_o go to 0. blk_data_o goes to 0. Any partial block is discarded.
- Words presented after blk_in=blk_total are not accepted (in_ready_o=0).

## Timing
- Reset values: in_ready_o=0, blk_valid_o=0, blk_data_o=0, busy_o=0, done_o=0, err_strb_o=0, state IDLE.
- start_i at cycle t -> busy_o=1 and in_ready_o=1 at t+1.
- Latency: 4th word accepted at cycle t -> blk_valid_o=1 at t+1.
- Throughput: 1 word/cycle and 1 block per 4 cycles when blk_ready_i is held at 1.
- Backpressure: with blk_ready_i=0, at most 2 blocks are buffered (output register plus asm). in_ready_o falls the cycle after the 8th word is accepted.
- blk_valid_o stays high and blk_data_o stays stable until accepted.
- Final block accepted at cycle t -> done_o=1 at t+1, busy_o=0 at t+1, IDLE at t+2.
- Asynchronous reset mid-job: all outputs return to their reset values immediately. No resume.

## Test plan
- Single block, nblocks=1, words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on consecutive cycles, blk_ready_i=1 -> blk_data_o=0xCCDDEEFF_8899AABB_44556677_00112233 one cycle after the 4th word; done_o pulses the cycle after the block is accepted.
- Streaming, nblocks=4, 16 words back-to-back, blk_ready_i=1 -> in_ready_o stays high for 16 cycles; 4 blocks in order; exactly 1 done_o pulse.
- Backpressure, nblocks=3, blk_ready_i=0 -> in_ready_o falls after the 8th word. Release blk_ready_i -> blocks 0 and 1 drain in order, then words 9-12 are accepted; no data loss.
- Strobe error: 2nd word sent with strb=4'h7 -> err_strb_o=1 from the next cycle until the next start_i; block data still contains the word.
- clear_i asserted after 2 words of block 0 -> IDLE next cycle with all outputs 0. A new start with nblocks=1 then produces a correct block built from fresh words only.
- nblocks=0 start -> done_o pulses at t+1, in_ready_o never asserts; start_i in RUN is ignored and blk_total is unchanged.
